// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller and its output decoder.
// Latency: n/a. Backpressure: n/a.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        TRAP      = 4'd10
    } mc_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } mc_cause_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } mc_ctrl_t;

    // States that own a memory access: these wait on mem_ready and are watched by the watchdog.
    function automatic logic is_mem_state(mc_state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational decode of controller state (+ mem_ready, trap cause) into datapath controls.
// Latency: 0 cycles. Backpressure: FETCH/MEM_WRITE strobes follow mem_ready; wr_en_i=0 kills PC/IR writes.
module mc_output_decode
    import mc_pkg::*;
(
    input  mc_state_t state_i,
    input  logic      mem_ready_i,
    input  mc_cause_t cause_i,
    input  logic      wr_en_i,
    output mc_ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.ior_d    = 1'b1;
            end
            MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.ior_d      = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
`endif
            TRAP: begin
                ctrl_o.illegal_op  = (cause_i == CAUSE_ILLEGAL);
                ctrl_o.mem_timeout = (cause_i == CAUSE_TIMEOUT);
            end
            default: ctrl_o = '0;
        endcase
        // Reset leaves the decode sitting in FETCH; PC and IR must not be written meanwhile.
        ctrl_o.pc_write = ctrl_o.pc_write & wr_en_i;
        ctrl_o.ir_write = ctrl_o.ir_write & wr_en_i;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller FSM (R/lw/sw/beq, j with MC_JUMP_EN) with memory watchdog and traps.
// Latency: R=4, lw=5, sw=4, beq=3, j=3 cycles; each mem_ready=0 cycle stalls one cycle, MEM_TIMEOUT stalls trap.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam int          CW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(MEM_TIMEOUT - 1);

    mc_state_t     state_q, state_d;
    mc_cause_t     cause_q, cause_d;
    logic [5:0]    op_q, op_d;
    logic [CW-1:0] wd_q, wd_d;
    mc_ctrl_t      ctrl;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        op_d    = op_q;
        wd_d    = '0;
        case (state_q)
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                op_d = op_code;
                case (op_code)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default: begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEM_ADDR:  state_d = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WRITE: if (mem_ready) state_d = FETCH;
            EXECUTE:   state_d = R_WB;
            TRAP: begin
                state_d = FETCH;
                cause_d = CAUSE_NONE;
            end
            default:   state_d = FETCH;
        endcase
        // Completion on the last tolerated cycle beats the watchdog: only a still-stalled access traps.
        if (is_mem_state(state_q) && !mem_ready) begin
            if (wd_q == WD_LAST) begin
                state_d = TRAP;
                cause_d = CAUSE_TIMEOUT;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cause_q <= CAUSE_NONE;
            op_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            op_q    <= op_d;
            wd_q    <= wd_d;
        end
    end

    mc_output_decode u_dec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .cause_i     (cause_q),
        .wr_en_i     (rst_n),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.ior_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign instr_done  = ctrl.instr_done;
    assign illegal_op  = ctrl.illegal_op;
    assign mem_timeout = ctrl.mem_timeout;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and randomized instructions checked against a latency/strobe model.
module tb_multicycle_control;

    localparam int TO = 4;
    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100, J_OP = 6'b000010, BAD_OP = 6'b111111;
    localparam int ST_FETCH = 0, ST_DEC = 1, ST_ADDR = 2, ST_RD = 3, ST_WB = 4;
    localparam int ST_EXE = 6, ST_RWB = 7, ST_TRAP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op, mem_timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    // Per-instruction observations
    int n_cyc, n_rw, n_mw, n_irw, n_pcw, n_done, n_ill, n_tmo, n_pcc, n_pcs2, beq_aluop;
    logic [3:0] st_tr [0:47];
    logic       mr_tr [0:47];
    logic       io_tr [0:47];

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected counts for one instruction, from opcode class and the planned memory stalls.
    task automatic model(input logic [5:0] op, input int fw, input int dw,
                         output int cyc, output int rw, output int mw, output int irw,
                         output int pcw, output int done, output int ill, output int tmo,
                         output int pcc, output int pcs2);
        int f;
        bit jump_ok;
`ifdef MC_JUMP_EN
        jump_ok = 1'b1;
`else
        jump_ok = 1'b0;
`endif
        {rw, mw, irw, pcw, done, ill, tmo, pcc, pcs2} = '0;
        if (fw >= TO) begin
            cyc = TO + 1;
            tmo = 1;
            return;
        end
        f   = fw + 1;
        irw = 1;
        pcw = 1;
        if (op == R_OP) begin
            cyc = f + 3; rw = 1; done = 1;
        end else if (op == LW_OP) begin
            if (dw >= TO) begin cyc = f + 2 + TO + 1; tmo = 1; end
            else begin cyc = f + 2 + dw + 2; rw = 1; done = 1; end
        end else if (op == SW_OP) begin
            if (dw >= TO) begin cyc = f + 2 + TO + 1; mw = TO; tmo = 1; end
            else begin cyc = f + 2 + dw + 1; mw = dw + 1; done = 1; end
        end else if (op == BEQ_OP) begin
            cyc = f + 2; pcc = 1; done = 1;
        end else if (op == J_OP && jump_ok) begin
            cyc = f + 2; pcw = 2; pcs2 = 1; done = 1;
        end else begin
            cyc = f + 2; ill = 1;
        end
    endtask

    // Runs one instruction from FETCH; a memory responder supplies fw fetch stalls and dw data stalls.
    task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int dw);
        int  waited = 0;
        bit  fin = 1'b0;
        bit  dec_seen = 1'b0;
        int  e_cyc, e_rw, e_mw, e_irw, e_pcw, e_done, e_ill, e_tmo, e_pcc, e_pcs2;
        {n_cyc, n_rw, n_mw, n_irw, n_pcw, n_done, n_ill, n_tmo, n_pcc, n_pcs2} = '0;
        beq_aluop = -1;
        @(negedge clk);
        chk({tag, "_start_fetch"}, 32'(state), ST_FETCH);
        op_code = op;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (dec_seen) op_code = 6'($urandom);
            if (MemRead || MemWrite) begin
                if (waited >= (IorD ? dw : fw)) begin mem_ready = 1'b1; waited = 0; end
                else begin mem_ready = 1'b0; waited++; end
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            if (c < 48) begin st_tr[c] = state; mr_tr[c] = MemRead; io_tr[c] = IorD; end
            n_cyc++;
            n_rw   += int'(RegWrite);
            n_mw   += int'(MemWrite);
            n_irw  += int'(IRWrite);
            n_pcw  += int'(PCWrite);
            n_done += int'(instr_done);
            n_ill  += int'(illegal_op);
            n_tmo  += int'(mem_timeout);
            n_pcc  += int'(PCWriteCond);
            n_pcs2 += int'(PCSource == 2'b10);
            if (PCWriteCond) beq_aluop = int'(ALUOp);
            if (ALUSrcB == 2'b11) dec_seen = 1'b1;
            if (instr_done || illegal_op || mem_timeout) fin = 1'b1;
        end
        chk({tag, "_terminated"}, 32'(fin), 1);
        model(op, fw, dw, e_cyc, e_rw, e_mw, e_irw, e_pcw, e_done, e_ill, e_tmo, e_pcc, e_pcs2);
        chk({tag, "_cycles"}, n_cyc, e_cyc);
        chk({tag, "_regwrite"}, n_rw, e_rw);
        chk({tag, "_memwrite"}, n_mw, e_mw);
        chk({tag, "_irwrite"}, n_irw, e_irw);
        chk({tag, "_pcwrite"}, n_pcw, e_pcw);
        chk({tag, "_done"}, n_done, e_done);
        chk({tag, "_illegal"}, n_ill, e_ill);
        chk({tag, "_timeout"}, n_tmo, e_tmo);
        chk({tag, "_pcwcond"}, n_pcc, e_pcc);
        chk({tag, "_pcsrc_jump"}, n_pcs2, e_pcs2);
        if (e_pcc == 1) chk({tag, "_beq_aluop"}, beq_aluop, 1);
    endtask

    initial begin
        logic [5:0] ops [0:4];
        ops[0] = R_OP; ops[1] = LW_OP; ops[2] = SW_OP; ops[3] = BEQ_OP; ops[4] = J_OP;

        // Reset: FETCH decode visible, write strobes suppressed even with mem_ready high
        mem_ready = 1'b1;
        #2;
        chk("rst_state", 32'(state), ST_FETCH);
        chk("rst_pcwrite", 32'(PCWrite), 0);
        chk("rst_irwrite", 32'(IRWrite), 0);
        chk("rst_memread", 32'(MemRead), 1);
        chk("rst_alusrcb", 32'(ALUSrcB), 1);
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_done", 32'(instr_done), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_instr("r", R_OP, 0, 0);
        chk("r_st0", 32'(st_tr[0]), ST_FETCH);
        chk("r_st1", 32'(st_tr[1]), ST_DEC);
        chk("r_st2", 32'(st_tr[2]), ST_EXE);
        chk("r_st3", 32'(st_tr[3]), ST_RWB);

        run_instr("lw_wait", LW_OP, 0, 2);
        chk("lw_st2", 32'(st_tr[2]), ST_ADDR);
        for (int i = 3; i < 6; i++) begin
            chk("lw_wait_state", 32'(st_tr[i]), ST_RD);
            chk("lw_wait_memread", 32'(mr_tr[i]), 1);
            chk("lw_wait_iord", 32'(io_tr[i]), 1);
        end
        chk("lw_st6", 32'(st_tr[6]), ST_WB);

        run_instr("beq", BEQ_OP, 0, 0);
        run_instr("sw", SW_OP, 0, 0);
        run_instr("illegal", BAD_OP, 0, 0);
        chk("illegal_st2", 32'(st_tr[2]), ST_TRAP);
        run_instr("jump", J_OP, 0, 0);
        run_instr("wd_fetch_trap", R_OP, TO, 0);
        chk("wd_fetch_trap_st", 32'(st_tr[TO]), ST_TRAP);
        run_instr("wd_fetch_edge", R_OP, TO - 1, 0);
        run_instr("wd_sw_trap", SW_OP, 1, TO);
        run_instr("wd_lw_edge", LW_OP, 0, TO - 1);
        run_instr("wd_lw_trap", LW_OP, 0, TO);

        // Reset in the middle of a stalled lw read
        @(negedge clk);
        op_code = LW_OP; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 chk("midrst_pre_state", 32'(state), ST_RD);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(state), ST_FETCH);
        chk("midrst_regwrite", 32'(RegWrite), 0);
        chk("midrst_pcwrite", 32'(PCWrite), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            int sel, fw, dw;
            sel = int'($urandom_range(0, 5));
            op  = (sel < 5) ? ops[sel] : 6'($urandom);
            fw  = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, TO - 1));
            dw  = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, TO - 1));
            run_instr("rand", op, fw, dw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS controller FSM that sequences the shared datapath: one memory, one ALU, IR, and the A/B/ALUOut holding registers.
- Supports R-format, lw, sw and beq (plus j when the optional feature is compiled in).
- Adds memory wait-state handshaking, a memory-timeout watchdog, and trap and illegal-opcode reporting.
- Sits beside the datapath and drives every mux select and write strobe each cycle.

Parameters:
- MEM_TIMEOUT, 8, maximum consecutive mem_ready=0 cycles tolerated in a memory state before trapping (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_code  input  6  IR[31:26]; sampled only in DECODE.
- mem_ready  input  1  memory completes the access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
- ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded.
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  output  1  one-cycle pulse in TRAP when the trap cause is an unknown opcode.
- mem_timeout  output  1  one-cycle pulse in TRAP when the trap cause is the watchdog.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, watchdog counter=0, trap cause cleared. During reset every output is 0 except the FETCH-state decode, which must not assert write strobes: PCWrite and IRWrite are forced to 0 while rst_n=0.
- Outputs are a combinational decode of the registered state. Any signal not listed for a state is 0 (never x).
- State outputs:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEM_READ: MemRead=1, IorD=1.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
  - MEM_WRITE: MemWrite=1, IorD=1, instr_done=mem_ready.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1.
  - TRAP: illegal_op or mem_timeout per the trap cause; no write strobes.
- Transitions:
  - FETCH → DECODE on mem_ready.
  - DECODE on op_code: 000000→EXECUTE; 100011 or 101011→MEM_ADDR; 000100→BRANCH; anything else→TRAP with cause illegal.
  - MEM_ADDR → MEM_READ for lw, → MEM_WRITE for sw. op_code is latched in DECODE; the live input is not re-sampled.
  - MEM_READ → MEM_WB on mem_ready.
  - EXECUTE → R_WB.
  - MEM_WRITE, MEM_WB, R_WB, BRANCH, TRAP → FETCH.
- Wait states: FETCH, MEM_READ and MEM_WRITE hold while mem_ready=0, keeping MemRead, MemWrite and IorD stable.
- Watchdog:
  - Counter increments on each mem_ready=0 cycle in a memory state and clears on state exit.
  - If mem_ready is still 0 when the counter reaches MEM_TIMEOUT-1, the next state is TRAP with cause timeout.
  - The access is abandoned: no PCWrite or IRWrite, no MemWrite in TRAP.
- Simultaneous mem_ready=1 on the timeout cycle: completion wins, no trap.
- Latency with mem_ready=1 throughout: R=4 cycles, lw=5, sw=4, beq=3. Each cycle of mem_ready=0 adds one cycle.
- Reset asserted mid-instruction: immediate return to FETCH. Pending RegWrite/MemWrite are dropped asynchronously.

Optional Feature:
- Macro MC_JUMP_EN.
- Defined: op_code 000010 in DECODE → JUMP state. JUMP asserts PCWrite=1, PCSource=10, instr_done=1, then → FETCH; j takes 3 cycles.
- Undefined: no JUMP state exists; 000010 is treated as illegal (→ TRAP, illegal_op pulse). PCSource never equals 10.

Decomposition:
- Package mc_pkg holds:
  - mc_state_t enum: FETCH=0, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP, TRAP.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
  - ALUOp, ALUSrcB and PCSource encoding constants.
- Sub-module mc_output_decode: combinational state + mem_ready → control outputs. The top level holds the state register, latched opcode, watchdog counter and trap cause.

Test Plan:
- R-format: op_code=000000, mem_ready=1 → states FETCH, DECODE, EXECUTE, R_WB; RegWrite=1, RegDst=1 in cycle 4 only; instr_done pulse in cycle 4; next cycle FETCH.
- lw with wait: op_code=100011, mem_ready=0 for first 2 MEM_READ cycles → 7 cycles total; MemRead and IorD held stable across the wait; RegWrite with MemtoReg=1 exactly once.
- beq then sw: beq → PCWriteCond=1, ALUOp=01 in cycle 3, 3 cycles total. sw → MemWrite=1 in cycle 4, RegWrite never asserted.
- Illegal opcode 111111 → TRAP in cycle 3; illegal_op pulse of 1 cycle; no RegWrite, MemWrite or PCWrite; FETCH in cycle 4.
- Watchdog, MEM_TIMEOUT=4: mem_ready held 0 in FETCH → TRAP after 4 wait cycles with mem_timeout=1 and PCWrite=IRWrite=0. Repeat with mem_ready=1 on the 4th cycle → DECODE, no trap.
- Reset mid-lw (rst_n=0 during MEM_READ) → state=FETCH asynchronously, no RegWrite. With MC_JUMP_EN: op_code=000010 → PCWrite=1, PCSource=10 in cycle 3. Without it: illegal_op pulse.
